// File: rtl/count_clusters_param.sv
// Pipelined popcount of the NBITS-wide VPF vector; optional peak-hold built when COUNT_CLUSTERS_PEAK_EN is defined.
// Latency T+3 cycles (T = log2 of the power-of-two 6-bit slice count); sticky/peak follow one cycle later.
// No backpressure: a new sample is accepted every cycle and there is no stall path.
module count_clusters_param #(
  parameter int NBITS      = 1536,
  parameter int OVF_THRESH = 8,
  parameter int CNT_W      = $clog2(NBITS + 1)
) (
  input  logic             clock4x,
  input  logic             reset,
  input  logic [NBITS-1:0] vpfs_i,
  input  logic             valid_i,
  input  logic             ovf_clear_i,
  input  logic             peak_clear_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             valid_o,
  output logic             overflow_o,
  output logic             ovf_sticky_o,
  output logic [CNT_W-1:0] peak_o
);

  localparam int N6_RAW = (NBITS + 5) / 6;
  localparam int T      = $clog2(N6_RAW);
  localparam int N6     = 1 << T;
  localparam int PW     = N6 * 6;
  localparam int SW     = 3 + T;
  localparam int NODES  = 2 * N6 - 1;

  logic [NBITS-1:0] vec_r;
  logic             vld_r;
  logic [PW-1:0]    vec_pad;
  logic [T:0]       vld_pipe;
  logic [SW-1:0]    node [NODES];
  logic [SW-1:0]    root;
  logic [CNT_W-1:0] root_cnt;
  logic             root_ovf;

  function automatic logic [2:0] ones6(input logic [5:0] s);
    logic [2:0] n;
    n = '0;
    for (int j = 0; j < 6; j++) n = n + {2'b00, s[j]};
    return n;
  endfunction

  always_comb begin
    vec_pad              = '0;
    vec_pad[NBITS-1:0]   = vec_r;
  end

  // Heap-ordered adder tree: leaves at N6-1.., node i sums children 2i+1 and 2i+2.
  // Every node of a given depth is one register stage, so samples never mix.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      vec_r    <= '0;
      vld_r    <= 1'b0;
      vld_pipe <= '0;
      for (int i = 0; i < NODES; i++) node[i] <= '0;
    end else begin
      vec_r       <= vpfs_i & {NBITS{valid_i}};
      vld_r       <= valid_i;
      vld_pipe[0] <= vld_r;
      for (int i = 1; i <= T; i++) vld_pipe[i] <= vld_pipe[i-1];
      for (int i = 0; i < N6; i++) node[N6-1+i] <= SW'(ones6(vec_pad[6*i +: 6]));
      for (int i = 0; i < N6 - 1; i++) node[i] <= node[2*i+1] + node[2*i+2];
    end
  end

  assign root     = node[0];
  assign root_cnt = CNT_W'(root);
  assign root_ovf = vld_pipe[T] && (32'(root) > 32'(OVF_THRESH));

  always_ff @(posedge clock4x) begin
    if (reset) begin
      cnt_o      <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      cnt_o      <= root_cnt;
      valid_o    <= vld_pipe[T];
      overflow_o <= root_ovf;
    end
  end

  // Set has priority so an overflow arriving with a clear is never lost.
  always_ff @(posedge clock4x) begin
    if (reset)                      ovf_sticky_o <= 1'b0;
    else if (valid_o && overflow_o) ovf_sticky_o <= 1'b1;
    else if (ovf_clear_i)           ovf_sticky_o <= 1'b0;
  end

`ifdef COUNT_CLUSTERS_PEAK_EN
  always_ff @(posedge clock4x) begin
    if (reset)                           peak_o <= '0;
    else if (peak_clear_i)               peak_o <= valid_o ? cnt_o : '0;
    else if (valid_o && cnt_o > peak_o)  peak_o <= cnt_o;
  end
`else
  logic peak_clear_unused;
  assign peak_clear_unused = peak_clear_i;
  assign peak_o            = '0;
`endif

endmodule

// File: tb/tb_count_clusters_param.sv
// Bench for count_clusters_param: NBITS=1536 directed vectors plus an NBITS=7 random stream, both checked against a popcount model.
module tb_count_clusters_param;

  localparam int NA = 1536, NB = 7;
  localparam int LA = 11, LB = 4;
  localparam int TA = 8, TB = 3;
  localparam int CA = 11, CB = 3;
  localparam int MAXC = 512;
`ifdef COUNT_CLUSTERS_PEAK_EN
  localparam int PEAK_ALL = 1536;
`else
  localparam int PEAK_ALL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NA-1:0] a_vec;
  logic          a_vld, a_rst, a_oclr, a_pclr;
  logic [CA-1:0] a_cnt, a_pk;
  logic          a_vo, a_ovf, a_st;
  logic [NB-1:0] b_vec;
  logic          b_vld, b_rst, b_oclr, b_pclr;
  logic [CB-1:0] b_cnt, b_pk;
  logic          b_vo, b_ovf, b_st;

  count_clusters_param #(.NBITS(NA), .OVF_THRESH(TA), .CNT_W(CA)) dut_a (
    .clock4x(clk), .reset(a_rst), .vpfs_i(a_vec), .valid_i(a_vld),
    .ovf_clear_i(a_oclr), .peak_clear_i(a_pclr), .cnt_o(a_cnt), .valid_o(a_vo),
    .overflow_o(a_ovf), .ovf_sticky_o(a_st), .peak_o(a_pk));

  count_clusters_param #(.NBITS(NB), .OVF_THRESH(TB), .CNT_W(CB)) dut_b (
    .clock4x(clk), .reset(b_rst), .vpfs_i(b_vec), .valid_i(b_vld),
    .ovf_clear_i(b_oclr), .peak_clear_i(b_pclr), .cnt_o(b_cnt), .valid_o(b_vo),
    .overflow_o(b_ovf), .ovf_sticky_o(b_st), .peak_o(b_pk));

  int cyc = 0, checks = 0, errors = 0;

  // Inputs seen at each edge, indexed by the cycle in which they were driven.
  int pc [2][MAXC];
  bit vl [2][MAXC], rs [2][MAXC], oc [2][MAXC], pk [2][MAXC];
  int ecnt [2][MAXC], epk [2][MAXC];
  bit evld [2][MAXC], eovf [2][MAXC], est [2][MAXC];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (cyc < MAXC) begin
      pc[0][cyc] = a_vld ? $countones(a_vec) : 0;
      vl[0][cyc] = a_vld; rs[0][cyc] = a_rst; oc[0][cyc] = a_oclr; pk[0][cyc] = a_pclr;
      pc[1][cyc] = b_vld ? $countones(b_vec) : 0;
      vl[1][cyc] = b_vld; rs[1][cyc] = b_rst; oc[1][cyc] = b_oclr; pk[1][cyc] = b_pclr;
    end
    cyc = cyc + 1;
  end

  // A sample driven in cycle n shows up in cycle n+L unless a reset was seen at any edge in between.
  task automatic model(input int d, input int c);
    int L, th, n, p;
    bit ok;
    L  = (d == 0) ? LA : LB;
    th = (d == 0) ? TA : TB;
    n  = c - L;
    ok = (n >= 0);
    if (ok) for (int r = n; r < c; r++) if (rs[d][r]) ok = 1'b0;
    if (ok) ok = vl[d][n];
    ecnt[d][c] = ok ? pc[d][n] : 0;
    evld[d][c] = ok;
    eovf[d][c] = ok && (ecnt[d][c] > th);
    p = c - 1;
    if (rs[d][p]) begin
      est[d][c] = 1'b0;
      epk[d][c] = 0;
    end else begin
      est[d][c] = (evld[d][p] && eovf[d][p]) ? 1'b1 : (oc[d][p] ? 1'b0 : est[d][p]);
      if (pk[d][p])                                   epk[d][c] = evld[d][p] ? ecnt[d][p] : 0;
      else if (evld[d][p] && ecnt[d][p] > epk[d][p])  epk[d][c] = ecnt[d][p];
      else                                            epk[d][c] = epk[d][p];
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      model(0, cyc);
      model(1, cyc);
      check("A.cnt", a_cnt, ecnt[0][cyc]);
      check("A.valid", a_vo, evld[0][cyc]);
      check("A.overflow", a_ovf, eovf[0][cyc]);
      check("A.sticky", a_st, est[0][cyc]);
`ifdef COUNT_CLUSTERS_PEAK_EN
      check("A.peak", a_pk, epk[0][cyc]);
      check("B.peak", b_pk, epk[1][cyc]);
`else
      check("A.peak", a_pk, 0);
      check("B.peak", b_pk, 0);
`endif
      check("B.cnt", b_cnt, ecnt[1][cyc]);
      check("B.valid", b_vo, evld[1][cyc]);
      check("B.overflow", b_ovf, eovf[1][cyc]);
      check("B.sticky", b_st, est[1][cyc]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one sample, then idle until it reaches the outputs.
  task automatic run_a(input logic [NA-1:0] v, input logic vin);
    a_vec = v; a_vld = vin;
    tick();
    a_vec = '0; a_vld = 1'b0;
    repeat (LA - 1) tick();
  endtask

  initial begin
    logic [NA-1:0] v;
    int dens;
    a_vec = '0; a_vld = 1'b0; a_rst = 1'b1; a_oclr = 1'b0; a_pclr = 1'b0;
    tick();
    tick();
    a_rst = 1'b0;
    check("A.reset_cnt", a_cnt, 0);
    check("A.reset_valid", a_vo, 0);
    check("A.reset_sticky", a_st, 0);

    run_a('0, 1'b1);
    check("A.zero_cnt", a_cnt, 0);
    check("A.zero_valid", a_vo, 1);
    check("A.zero_ovf", a_ovf, 0);

    run_a('1, 1'b1);
    check("A.all_cnt", a_cnt, 1536);
    check("A.all_ovf", a_ovf, 1);
    tick();
    check("A.all_sticky", a_st, 1);
    check("A.all_peak", a_pk, PEAK_ALL);

    v = '0;
    v[0] = 1'b1; v[7] = 1'b1; v[100] = 1'b1; v[200] = 1'b1;
    v[511] = 1'b1; v[777] = 1'b1; v[1200] = 1'b1; v[1535] = 1'b1;
    run_a(v, 1'b1);
    check("A.eight_cnt", a_cnt, 8);
    check("A.eight_ovf", a_ovf, 0);
    v[1000] = 1'b1;
    run_a(v, 1'b1);
    check("A.nine_cnt", a_cnt, 9);
    check("A.nine_ovf", a_ovf, 1);

    run_a('1, 1'b0);
    check("A.inval_cnt", a_cnt, 0);
    check("A.inval_valid", a_vo, 0);
    check("A.inval_ovf", a_ovf, 0);
    tick();
    check("A.inval_sticky", a_st, 1);

    a_oclr = 1'b1;
    tick();
    a_oclr = 1'b0;
    check("A.quiet_clear", a_st, 0);

    run_a('1, 1'b1);
    a_oclr = 1'b1;
    tick();
    check("A.set_beats_clear", a_st, 1);
    tick();
    a_oclr = 1'b0;
    check("A.late_clear", a_st, 0);

    a_pclr = 1'b1;
    tick();
    a_pclr = 1'b0;
    check("A.peak_clear", a_pk, 0);

    for (int i = 0; i < 40; i++) begin
      dens = (i % 3 == 0) ? 400 : 16;
      for (int j = 0; j < NA; j++) v[j] = ($urandom_range(0, dens - 1) == 0);
      a_vec = v;
      a_vld = ($urandom_range(0, 4) != 0);
      a_rst = (i == 20);
      tick();
      if (i == 20) begin
        check("A.midreset_valid", a_vo, 0);
        check("A.midreset_sticky", a_st, 0);
      end
    end
    a_vec = '0; a_vld = 1'b0; a_rst = 1'b0;
    repeat (LA + 3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    b_vec = '0; b_vld = 1'b0; b_rst = 1'b1; b_oclr = 1'b0; b_pclr = 1'b0;
    forever begin
      tick();
      b_rst = (cyc < 2) || (cyc == 30);
      if (cyc == 50) begin
        b_vec = 7'h7F;
        b_vld = 1'b1;
      end else begin
        b_vec = 7'($urandom);
        b_vld = ($urandom_range(0, 3) != 0);
      end
      b_oclr = ($urandom_range(0, 7) == 0);
      b_pclr = ($urandom_range(0, 15) == 0);
      if (cyc == 31) begin
        check("B.midreset_valid", b_vo, 0);
        check("B.midreset_cnt", b_cnt, 0);
        check("B.midreset_sticky", b_st, 0);
      end
      if (cyc == 54) begin
        check("B.all_cnt", b_cnt, 7);
        check("B.all_valid", b_vo, 1);
        check("B.all_ovf", b_ovf, 1);
      end
    end
  end

endmodule
